// File: rtl/battle_engine.sv
// battle_engine
// Turn-based combat resolver for the RPG datapath. The collision detector
// pulses battle_start. The engine then collects one attack choice per side
// through a valid handshake and resolves both attacks in the same cycle.
// Health saturates at zero. Sword and bat draw on limited ammo, while
// punch and kick are unlimited. Win/lose/draw goes to the HUD overlay.
//
// Optional feature macro: BATTLE_ACCURACY_EN
//   When it is defined, an 8-bit LFSR decides whether each attack hits.
//   When it is undefined, every attack hits and the ACC_* parameters are unused.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   battle_start   pulse that (re)starts a battle from IDLE or DONE
//   player_valid   player choice present this cycle
//   player_choice  00 punch, 01 kick, 10 sword, 11 bat
//   enemy_valid    enemy choice present this cycle
//   enemy_choice   same encoding as player_choice
//   player_hp      player health
//   enemy_hp       enemy health
//   player_sword, player_bat, enemy_sword, enemy_bat   remaining ammo
//   busy           high in COLLECT or RESOLVE
//   round_done     one-cycle pulse after each resolved round
//   player_win, enemy_win, draw   sticky result flags
module battle_engine #(
  parameter int HPW        = 7,
  parameter int AW         = 5,
  parameter int HP_MAX     = 100,
  parameter int SWORD_INIT = 4,
  parameter int BAT_INIT   = 3,
  parameter int DMG_P      = 5,
  parameter int DMG_K      = 10,
  parameter int DMG_S      = 20,
  parameter int DMG_B      = 40,
  parameter int ACC_P      = 255,
  parameter int ACC_K      = 204,
  parameter int ACC_S      = 102,
  parameter int ACC_B      = 77
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           battle_start,
  input  logic           player_valid,
  input  logic [1:0]     player_choice,
  input  logic           enemy_valid,
  input  logic [1:0]     enemy_choice,
  output logic [HPW-1:0] player_hp,
  output logic [HPW-1:0] enemy_hp,
  output logic [AW-1:0]  player_sword,
  output logic [AW-1:0]  player_bat,
  output logic [AW-1:0]  enemy_sword,
  output logic [AW-1:0]  enemy_bat,
  output logic           busy,
  output logic           round_done,
  output logic           player_win,
  output logic           enemy_win,
  output logic           draw
);

  typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, DONE} state_t;

  // All damage arithmetic happens at health width.
  localparam logic [HPW-1:0] HP_MAX_W  = HPW'(HP_MAX);
  localparam logic [HPW-1:0] DMG_P_W   = HPW'(DMG_P);
  localparam logic [HPW-1:0] DMG_K_W   = HPW'(DMG_K);
  localparam logic [HPW-1:0] DMG_S_W   = HPW'(DMG_S);
  localparam logic [HPW-1:0] DMG_B_W   = HPW'(DMG_B);
  localparam logic [AW-1:0]  SWORD_I_W = AW'(SWORD_INIT);
  localparam logic [AW-1:0]  BAT_I_W   = AW'(BAT_INIT);
  localparam logic [AW-1:0]  AMMO_ONE  = AW'(1);

  state_t         state, state_next;
  logic           player_pend, enemy_pend;
  logic [1:0]     player_sel, enemy_sel;
  logic           player_hit, enemy_hit;
  logic [HPW-1:0] player_dmg, enemy_dmg;
  logic [HPW-1:0] player_hp_new, enemy_hp_new;
  logic [AW-1:0]  player_sword_new, player_bat_new;
  logic [AW-1:0]  enemy_sword_new, enemy_bat_new;
  logic           player_take, enemy_take;

  // Base damage of a weapon. An empty sword or bat deals nothing.
  function automatic logic [HPW-1:0] weapon_dmg(input logic [1:0] sel,
                                                input logic [AW-1:0] sword,
                                                input logic [AW-1:0] bat);
    logic [HPW-1:0] d;
    case (sel)
      2'b00:   d = DMG_P_W;
      2'b01:   d = DMG_K_W;
      2'b10:   d = (sword != '0) ? DMG_S_W : '0;
      default: d = (bat != '0) ? DMG_B_W : '0;
    endcase
    return d;
  endfunction

`ifdef BATTLE_ACCURACY_EN
  logic [7:0] lfsr;

  // Hit threshold for each weapon.
  function automatic logic [7:0] acc_thresh(input logic [1:0] sel);
    logic [7:0] t;
    case (sel)
      2'b00:   t = 8'(ACC_P);
      2'b01:   t = 8'(ACC_K);
      2'b10:   t = 8'(ACC_S);
      default: t = 8'(ACC_B);
    endcase
    return t;
  endfunction

  // Free-running Fibonacci LFSR with taps 8,6,5,4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // The enemy draws from the nibble-swapped LFSR value, so the two sides
  // do not roll identically.
  assign player_hit = (lfsr < acc_thresh(player_sel));
  assign enemy_hit  = ({lfsr[3:0], lfsr[7:4]} < acc_thresh(enemy_sel));
`else
  assign player_hit = 1'b1;
  assign enemy_hit  = 1'b1;
`endif

  // Both damages are computed from the pre-round state, so the exchange is
  // simultaneous. A miss still consumes ammo.
  always_comb begin
    player_dmg       = player_hit ? weapon_dmg(player_sel, player_sword, player_bat) : '0;
    enemy_dmg        = enemy_hit  ? weapon_dmg(enemy_sel, enemy_sword, enemy_bat)    : '0;
    enemy_hp_new     = (player_dmg >= enemy_hp) ? '0 : enemy_hp - player_dmg;
    player_hp_new    = (enemy_dmg >= player_hp) ? '0 : player_hp - enemy_dmg;
    player_sword_new = player_sword;
    player_bat_new   = player_bat;
    enemy_sword_new  = enemy_sword;
    enemy_bat_new    = enemy_bat;
    if (player_sel == 2'b10 && player_sword != '0) player_sword_new = player_sword - AMMO_ONE;
    if (player_sel == 2'b11 && player_bat   != '0) player_bat_new   = player_bat   - AMMO_ONE;
    if (enemy_sel  == 2'b10 && enemy_sword  != '0) enemy_sword_new  = enemy_sword  - AMMO_ONE;
    if (enemy_sel  == 2'b11 && enemy_bat    != '0) enemy_bat_new    = enemy_bat    - AMMO_ONE;
  end

  // A side's choice is taken only while that side has nothing pending.
  assign player_take = player_valid && !player_pend;
  assign enemy_take  = enemy_valid  && !enemy_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A side counts as ready if it was already pending or if it is accepted
  // on this same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (battle_start) state_next = COLLECT;
      COLLECT: begin
        if ((player_pend || player_valid) && (enemy_pend || enemy_valid))
          state_next = RESOLVE;
      end
      RESOLVE: begin
        if (player_hp_new == '0 || enemy_hp_new == '0) state_next = DONE;
        else                                           state_next = COLLECT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_hp    <= HP_MAX_W;
      enemy_hp     <= HP_MAX_W;
      player_sword <= SWORD_I_W;
      player_bat   <= BAT_I_W;
      enemy_sword  <= SWORD_I_W;
      enemy_bat    <= BAT_I_W;
      player_pend  <= 1'b0;
      enemy_pend   <= 1'b0;
      player_sel   <= 2'b00;
      enemy_sel    <= 2'b00;
      round_done   <= 1'b0;
      player_win   <= 1'b0;
      enemy_win    <= 1'b0;
      draw         <= 1'b0;
    end else begin
      round_done <= (state == RESOLVE);
      case (state)
        IDLE, DONE: begin
          if (battle_start) begin
            player_hp    <= HP_MAX_W;
            enemy_hp     <= HP_MAX_W;
            player_sword <= SWORD_I_W;
            player_bat   <= BAT_I_W;
            enemy_sword  <= SWORD_I_W;
            enemy_bat    <= BAT_I_W;
            player_win   <= 1'b0;
            enemy_win    <= 1'b0;
            draw         <= 1'b0;
          end
        end
        COLLECT: begin
          if (player_take) begin
            player_sel  <= player_choice;
            player_pend <= 1'b1;
          end
          if (enemy_take) begin
            enemy_sel  <= enemy_choice;
            enemy_pend <= 1'b1;
          end
        end
        RESOLVE: begin
          player_hp    <= player_hp_new;
          enemy_hp     <= enemy_hp_new;
          player_sword <= player_sword_new;
          player_bat   <= player_bat_new;
          enemy_sword  <= enemy_sword_new;
          enemy_bat    <= enemy_bat_new;
          player_pend  <= 1'b0;
          enemy_pend   <= 1'b0;
          if (player_hp_new == '0 && enemy_hp_new == '0) draw       <= 1'b1;
          else if (player_hp_new == '0)                  enemy_win  <= 1'b1;
          else if (enemy_hp_new == '0)                   player_win <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == COLLECT) || (state == RESOLVE);

endmodule

// File: tb/tb_battle_engine.sv
// tb_battle_engine
// Directed bench for battle_engine in its default build (all attacks hit).
// Inputs change #1 after the rising edge, and outputs are sampled there too.
module tb_battle_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       battle_start;
  logic       player_valid;
  logic [1:0] player_choice;
  logic       enemy_valid;
  logic [1:0] enemy_choice;
  logic [6:0] player_hp, enemy_hp;
  logic [4:0] player_sword, player_bat, enemy_sword, enemy_bat;
  logic       busy, round_done, player_win, enemy_win, draw;

  int checks = 0;
  int errors = 0;

  battle_engine dut (
    .clk(clk), .rst_n(rst_n), .battle_start(battle_start),
    .player_valid(player_valid), .player_choice(player_choice),
    .enemy_valid(enemy_valid), .enemy_choice(enemy_choice),
    .player_hp(player_hp), .enemy_hp(enemy_hp),
    .player_sword(player_sword), .player_bat(player_bat),
    .enemy_sword(enemy_sword), .enemy_bat(enemy_bat),
    .busy(busy), .round_done(round_done),
    .player_win(player_win), .enemy_win(enemy_win), .draw(draw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic start, input logic pv, input logic [1:0] pc,
                                input logic ev, input logic [1:0] ec);
    battle_start  = start;
    player_valid  = pv;
    player_choice = pc;
    enemy_valid   = ev;
    enemy_choice  = ec;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input int php, input int ehp,
                           input int ps, input int pb, input int es, input int eb,
                           input int bz, input int pw, input int ew, input int dr);
    check_output({tag, ".player_hp"},    32'(player_hp),    32'(php));
    check_output({tag, ".enemy_hp"},     32'(enemy_hp),     32'(ehp));
    check_output({tag, ".player_sword"}, 32'(player_sword), 32'(ps));
    check_output({tag, ".player_bat"},   32'(player_bat),   32'(pb));
    check_output({tag, ".enemy_sword"},  32'(enemy_sword),  32'(es));
    check_output({tag, ".enemy_bat"},    32'(enemy_bat),    32'(eb));
    check_output({tag, ".busy"},         32'(busy),         32'(bz));
    check_output({tag, ".player_win"},   32'(player_win),   32'(pw));
    check_output({tag, ".enemy_win"},    32'(enemy_win),    32'(ew));
    check_output({tag, ".draw"},         32'(draw),         32'(dr));
  endtask

  // One full round: both choices on the same edge, then the resolve edge.
  task automatic play_round(input string tag, input logic [1:0] pc, input logic [1:0] ec);
    apply_stimulus(1'b0, 1'b1, pc, 1'b1, ec);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    check_output({tag, ".busy_resolve"}, 32'(busy), 32'd1);
    tick();
    check_output({tag, ".round_done"}, 32'(round_done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    #12;
    check_all("reset", 100, 100, 4, 3, 4, 3, 0, 0, 0, 0);
    check_output("reset.round_done", 32'(round_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] bat vs punch");
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    tick();
    check_output("start.busy", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 1'b1, 2'b11, 1'b1, 2'b00);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    check_output("s1.hp_before", 32'(enemy_hp), 32'd100);
    check_output("s1.rd_before", 32'(round_done), 32'd0);
    tick();
    check_all("s1", 95, 60, 4, 2, 4, 3, 1, 0, 0, 0);
    check_output("s1.round_done", 32'(round_done), 32'd1);
    tick();
    check_output("s1.round_done_low", 32'(round_done), 32'd0);

    $display("[TB] reset while busy");
    apply_stimulus(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midreset", 100, 100, 4, 3, 4, 3, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] sword exhaustion");
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) play_round("s2.sword", 2'b10, 2'b00);
    check_all("s2.after4", 80, 20, 0, 3, 4, 3, 1, 0, 0, 0);
    play_round("s2.empty", 2'b10, 2'b00);
    check_all("s2.after5", 75, 20, 0, 3, 4, 3, 1, 0, 0, 0);

    $display("[TB] saturating finish");
    play_round("s3", 2'b11, 2'b00);
    check_all("s3", 70, 0, 0, 2, 4, 3, 0, 1, 0, 0);

    // Valids are dropped in DONE.
    apply_stimulus(1'b0, 1'b1, 2'b11, 1'b1, 2'b11);
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    check_all("done_drop", 70, 0, 0, 2, 4, 3, 0, 1, 0, 0);

    $display("[TB] draw");
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    check_all("restart", 100, 100, 4, 3, 4, 3, 1, 0, 0, 0);
    play_round("s4.bat1", 2'b11, 2'b11);
    play_round("s4.bat2", 2'b11, 2'b11);
    play_round("s4.kick", 2'b01, 2'b01);
    play_round("s4.punch", 2'b00, 2'b00);
    check_all("s4.hp5", 5, 5, 4, 1, 4, 1, 1, 0, 0, 0);
    play_round("s4.final", 2'b00, 2'b00);
    check_all("s4.draw", 0, 0, 4, 1, 4, 1, 0, 0, 0, 1);

    $display("[TB] first choice stands");
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
    tick();
    apply_stimulus(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
    tick();
    apply_stimulus(1'b0, 1'b1, 2'b11, 1'b0, 2'b00);
    tick();
    check_all("s5.pending", 100, 100, 4, 3, 4, 3, 1, 0, 0, 0);
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, 2'b00);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    check_output("s5.rd_before", 32'(round_done), 32'd0);
    tick();
    check_all("s5", 95, 90, 4, 3, 4, 3, 1, 0, 0, 0);
    check_output("s5.round_done", 32'(round_done), 32'd1);

    #2;
    rst_n = 1'b0;
    #1;
    check_all("final_reset", 100, 100, 4, 3, 4, 3, 0, 0, 0, 0);
    check_output("final_reset.round_done", 32'(round_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
